// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : byte_serializer
// Purpose  : Parallel-to-serial converter placed after the registered
//            rotator. Accepts a WIDTH-bit word over a valid/ready handshake
//            and shifts it out one bit per bit_en strobe. A one-entry hold
//            buffer lets back-to-back words stream with no idle gap.
// Ports    : clk       - clock, rising edge
//            clear     - asynchronous active-low reset
//            in_data   - parallel word in
//            in_valid  - in_data is valid
//            in_ready  - word can be accepted this cycle
//            bit_en    - bit-rate strobe; output advances only when high
//            ser_out   - current serial bit (registered)
//            ser_valid - ser_out carries a frame bit (registered)
//            ser_last  - ser_out is the last bit of the word (registered)
//            busy      - frame in progress or hold buffer occupied
// Revision : 1.0 - initial release
// ============================================================================
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  C_LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_ser_last;

  state_t           w_state;
  logic [WIDTH-1:0] w_shift;
  logic [CW-1:0]    w_cnt;
  logic [WIDTH-1:0] w_hold;
  logic             w_hold_full;
  logic             w_ser_out;
  logic             w_ser_valid;
  logic             w_ser_last;
  logic             w_accept;
  logic             w_direct;   // accepted word goes straight to the shift reg

  // Bit currently presented: the end of the shift register facing the line.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? word[0] : word[WIDTH-1];
  endfunction

  // Advance by one bit, moving the next bit to the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? (word >> 1) : (word << 1);
  endfunction

  // Ready depends only on the hold buffer, never on in_valid.
  assign in_ready = ~r_hold_full;
  assign w_accept = in_valid & ~r_hold_full;

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_cnt       = r_cnt;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_direct    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift  = in_data;
          w_cnt    = '0;
          w_state  = S_SHIFT;
          w_direct = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_en) begin
          if (r_cnt == C_LAST_IDX) begin
            // Word end: chain the next word in with no gap if one exists.
            if (r_hold_full) begin
              w_shift     = r_hold;
              w_hold_full = 1'b0;
              w_cnt       = '0;
            end else if (w_accept) begin
              w_shift  = in_data;
              w_cnt    = '0;
              w_direct = 1'b1;
            end else begin
              w_shift = '0;
              w_cnt   = '0;
              w_state = S_IDLE;
            end
          end else begin
            w_shift = advance(r_shift);
            w_cnt   = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Any accept not consumed directly by the shift register parks in hold.
    if (w_accept && !w_direct) begin
      w_hold      = in_data;
      w_hold_full = 1'b1;
    end

    // Output flops follow the next state, so they hold whenever the shift
    // state holds (bit_en low) and clear to zero on return to idle.
    w_ser_valid = (w_state == S_SHIFT);
    w_ser_out   = w_ser_valid & head_bit(w_shift);
    w_ser_last  = w_ser_valid & (w_cnt == C_LAST_IDX);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_cnt       <= w_cnt;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_ser_out   <= w_ser_out;
      r_ser_valid <= w_ser_valid;
      r_ser_last  <= w_ser_last;
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state == S_SHIFT) | r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_serializer
// Purpose  : Self-checking bench for byte_serializer. Two instances (LSB
//            first and MSB first) share one stimulus stream and are compared
//            every cycle against a word/bit-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_en;

  logic l_ready, l_out, l_valid, l_last, l_busy;
  logic m_ready, m_out, m_valid, m_last, m_busy;

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .bit_en(bit_en), .ser_out(l_out),
    .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy)
  );

  byte_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .bit_en(bit_en), .ser_out(m_out),
    .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the word being sent, the index of the bit on the
  // line, and a list of words waiting behind it (at most one).
  bit           m_act;
  bit [W-1:0]   m_word;
  int           m_idx;
  bit [W-1:0]   m_pend[$];
  bit           m_acc;

  // Stimulus control
  bit [W-1:0]   txq[$];
  int           en_mode;   // 0: always on, 1: 1,0,0 pattern, 2: random
  int           en_ph;
  bit           rnd_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_word = '0;
    m_idx  = 0;
    m_acc  = 1'b0;
    m_pend.delete();
  endtask

  // One rising edge worth of behaviour, using the inputs present before it.
  task automatic model_step();
    bit acc, used, was_act;
    m_acc = 1'b0;
    if (!clear) begin
      model_reset();
      return;
    end
    acc     = in_valid && (m_pend.size() == 0);
    m_acc   = acc;
    used    = 1'b0;
    was_act = m_act;
    if (m_act && bit_en) begin
      if (m_idx == W - 1) begin
        if (m_pend.size() > 0) begin
          m_word = m_pend.pop_front();
          m_idx  = 0;
        end else if (acc) begin
          m_word = in_data;
          m_idx  = 0;
          used   = 1'b1;
        end else begin
          m_act = 1'b0;
        end
      end else begin
        m_idx++;
      end
    end
    if (acc && !used) begin
      if (!was_act) begin
        m_act  = 1'b1;
        m_word = in_data;
        m_idx  = 0;
      end else begin
        m_pend.push_back(in_data);
      end
    end
  endtask

  task automatic compare_all();
    bit e_busy, e_rdy, e_last, e_l, e_m;
    e_busy = m_act || (m_pend.size() > 0);
    e_rdy  = (m_pend.size() == 0);
    e_last = m_act && (m_idx == W - 1);
    e_l    = m_act ? m_word[m_idx] : 1'b0;
    e_m    = m_act ? m_word[W-1-m_idx] : 1'b0;
    check("lsb_valid", l_valid, m_act);
    check("lsb_out",   l_out,   e_l);
    check("lsb_last",  l_last,  e_last);
    check("lsb_busy",  l_busy,  e_busy);
    check("lsb_ready", l_ready, e_rdy);
    check("msb_valid", m_valid, m_act);
    check("msb_out",   m_out,   e_m);
    check("msb_last",  m_last,  e_last);
    check("msb_busy",  m_busy,  e_busy);
    check("msb_ready", m_ready, e_rdy);
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic cycle();
    bit pulse;
    in_valid = (txq.size() > 0) || (rnd_valid && ($urandom_range(0, 1) == 1));
    in_data  = (txq.size() > 0) ? txq[0] : W'($urandom);
    case (en_mode)
      0:       bit_en = 1'b1;
      1:       begin bit_en = (en_ph % 3 == 0); en_ph++; end
      default: bit_en = ($urandom_range(0, 3) != 0);
    endcase
    pulse = rnd_valid && ($urandom_range(0, 149) == 0);
    if (pulse) begin
      #2;
      clear = 1'b0;
      #1;
      model_reset();
      compare_all();
    end
    @(posedge clk);
    model_step();
    if (m_acc && txq.size() > 0) void'(txq.pop_front());
    #1;
    compare_all();
    if (pulse) clear = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_act && m_pend.size() == 0 && txq.size() == 0) begin
        idle = 1'b1;
        break;
      end
      cycle();
    end
    check("drain_done", idle, 1'b1);
    repeat (2) cycle();
  endtask

  initial begin
    bit found;
    clear     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    bit_en    = 1'b0;
    en_mode   = 0;
    en_ph     = 0;
    rnd_valid = 1'b0;
    model_reset();

    // Reset held for 3 cycles, then idle with no input.
    #2;
    clear = 1'b0;
    #1;
    compare_all();
    @(posedge clk);
    #1;
    repeat (3) cycle();
    clear = 1'b1;
    repeat (4) cycle();

    // Single word.
    txq.push_back(8'hA5);
    drain(30);

    // Two words streamed back to back.
    txq.push_back(8'h3C);
    txq.push_back(8'hC3);
    drain(40);

    // Paced by a sparse bit_en strobe.
    en_mode = 1;
    en_ph   = 0;
    txq.push_back(8'hF0);
    drain(60);
    en_mode = 0;

    // Three words offered back to back; the third has to stall.
    txq.push_back(8'h01);
    txq.push_back(8'h02);
    txq.push_back(8'h03);
    drain(60);

    // Asynchronous clear mid-frame with a word waiting in hold.
    txq.push_back(8'hFF);
    txq.push_back(8'h55);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (m_act && m_word == 8'hFF && m_idx == 4 && m_pend.size() > 0) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_bit4", found, 1'b1);
    txq.delete();
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    compare_all();
    cycle();
    clear = 1'b1;
    repeat (12) cycle();
    txq.push_back(8'h96);
    drain(30);

    // Randomized traffic, pacing and occasional clears.
    rnd_valid = 1'b1;
    en_mode   = 2;
    repeat (1500) cycle();
    rnd_valid = 1'b0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
